image_loader: RTL and testbench
===============================

# image_loader

Parametrised frame loader between the serial pin interface and the CNN datapath. It accepts a stream of PIN_W-bit words over a valid/ready handshake and writes them, in order, into a flat WORDS×PIN_W register image read by the convolution stage. Unlike the fixed 12-pin/200-word memory interface, it owns its own write pointer and tracks frame completion. It also reports overflow and supports back-pressure and in-place restart.

## Interface
- PIN_W, 12, word width in bits (pins sampled per cycle)
- WORDS, 200, words per frame; image size is PIN_W*WORDS bits
- CW, $clog2(WORDS+1), width of word_count (derived, not overridden)

- clk  in  1  clock; all state updates on rising edge
- rst_b  in  1  reset; one clock, reset is asynchronous and active-low
- clear  in  1  synchronous restart of the frame (pointer, flags, checksum)
- hold  in  1  consumer back-pressure; forces in_ready low
- in_valid  in  1  in_data carries a word this cycle
- in_data  in  PIN_W  word; in_data[PIN_W-1] corresponds to pin0
- in_ready  out  1  loader accepts a word this cycle
- word_count  out  CW  words accepted in current frame, 0..WORDS
- loaded  out  1  frame complete (level)
- frame_done  out  1  one-cycle pulse on frame completion
- overflow  out  1  sticky: in_valid seen while FULL
- checksum  out  PIN_W  running XOR of accepted words (see Configuration)
- mem  out  PIN_W*WORDS  frame image, declared [0:PIN_W*WORDS-1]

## Operation
- States: LOAD, FULL. Reset enters LOAD.
- in_ready = (state==LOAD) & ~hold & ~clear. Combinational; no dependency on in_valid.
- Accept = in_valid & in_ready.
- On accept, word k = word_count is written to mem[k*PIN_W +: PIN_W]. in_data[PIN_W-1] lands at mem[k*PIN_W] and in_data[0] at mem[k*PIN_W+PIN_W-1]. word_count then increments. All other mem bits hold.
- Accept with word_count==WORDS-1 writes the last word, sets word_count=WORDS, moves to FULL, sets loaded=1 and asserts frame_done.
- FULL: no writes. in_valid=1 sets overflow, which stays set until clear or reset. mem is stable for the consumer.
- clear (any state): word_count=0, state=LOAD, loaded=0, overflow=0, checksum=0.
  - mem is retained, not zeroed. The next frame overwrites it word by word.
  - clear has priority over a simultaneous accept; that word is dropped, consistent with in_ready=0.
- hold in LOAD pauses acceptance only. It has no effect in FULL.

## Timing
- Reset values: mem=0, word_count=0, loaded=0, frame_done=0, overflow=0, checksum=0, state=LOAD. in_ready follows hold/clear combinationally (1 if both are low).
- Write latency is 1 cycle: word accepted at edge N is visible on mem after edge N.
- Throughput is 1 word/cycle. A full frame needs WORDS accepting cycles.
- frame_done is high exactly the one cycle after the edge that accepted the last word, coincident with loaded rising. It is not reasserted until the next full frame.
- overflow rises the cycle after the first in_valid sampled in FULL.
- rst_b low mid-frame asynchronously clears all state including mem. A partial frame is lost.
- clear in the same cycle as the last-word accept: clear wins, no frame_done, and the state is LOAD with word_count=0.
- WORDS=1: the first accept goes straight to FULL.

## Configuration
- LOADER_CHECKSUM_EN defined: checksum <= checksum ^ in_data on every accept. It is cleared by reset/clear and frozen in FULL, so at frame_done it holds the XOR of all WORDS words.
- Not defined: the checksum port is still present but tied to 0, and no checksum register is synthesised.

## Test plan
- Reset, then stream 200 words with in_data=k (k=0..199) and in_valid constantly high. Expect mem[k*12+:12]==k, word_count=200, loaded=1, and frame_done high for exactly 1 cycle, one cycle after word 199 is accepted.
- hold high for cycles 50–59 while in_valid stays high. Expect in_ready=0 and word_count frozen at 50; the frame completes 10 cycles later with no word skipped or duplicated.
- After FULL, drive in_valid=1 with in_data=12'hFFF. Expect overflow=1 next cycle and mem unchanged.
- Issue clear during FULL, then load 200 words of 12'hA5A. Expect overflow=0 and loaded=0 right after the clear, and mem all 12'hA5A at the end.
- Deassert rst_b at word 120 mid-frame. Expect immediately mem=0, word_count=0 and loaded=0, with no frame_done.
- With LOADER_CHECKSUM_EN, words k=0..199 give checksum=0 at frame_done (XOR 0..199 = 0); words 1..200 give checksum = XOR(1..200) = 200 (12'h0C8). Without the macro, checksum stays 0.

Source files
------------

// File: rtl/image_loader.sv
// Frame loader: streams PIN_W-bit words into a flat WORDS*PIN_W image and tracks frame completion.
// Optional feature macro: LOADER_CHECKSUM_EN (running XOR of accepted words on the checksum port).
module image_loader #(
  parameter int PIN_W = 12,
  parameter int WORDS = 200,
  localparam int CW = $clog2(WORDS + 1)
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     clear,
  input  logic                     hold,
  input  logic                     in_valid,
  input  logic [PIN_W-1:0]         in_data,
  output logic                     in_ready,
  output logic [CW-1:0]            word_count,
  output logic                     loaded,
  output logic                     frame_done,
  output logic                     overflow,
  output logic [PIN_W-1:0]         checksum,
  output logic [0:PIN_W*WORDS-1]   mem
);

  // state | meaning
  // LOAD  | accepting words; word_count is the next slot to write
  // FULL  | frame complete; mem frozen, any in_valid flags overflow
  typedef enum logic {LOAD, FULL} state_t;

  state_t state;
  logic   accept;

  assign in_ready = (state == LOAD) & ~hold & ~clear;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= LOAD;
      word_count <= '0;
      loaded     <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      mem        <= '0;
    end else begin
      frame_done <= 1'b0;
      if (clear) begin
        // mem is deliberately kept; the next frame overwrites it word by word
        state      <= LOAD;
        word_count <= '0;
        loaded     <= 1'b0;
        overflow   <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            if (accept) begin
              for (int i = 0; i < WORDS; i++) begin
                if (word_count == CW'(i)) mem[i*PIN_W +: PIN_W] <= in_data;
              end
              word_count <= word_count + CW'(1);
              if (word_count == CW'(WORDS - 1)) begin
                state      <= FULL;
                loaded     <= 1'b1;
                frame_done <= 1'b1;
              end
            end
          end
          FULL: begin
            if (in_valid) overflow <= 1'b1;
          end
          default: state <= LOAD;
        endcase
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [PIN_W-1:0] sum_q;

  // accept is already false in FULL and under clear, so the sum freezes at frame end
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)      sum_q <= '0;
    else if (clear)  sum_q <= '0;
    else if (accept) sum_q <= sum_q ^ in_data;
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_image_loader.sv
// Directed self-checking bench for image_loader (default parameters, PIN_W=12, WORDS=200).
module tb_image_loader;

  localparam int PIN_W = 12;
  localparam int WORDS = 200;

  logic                   clk;
  logic                   rst_b;
  logic                   clear;
  logic                   hold;
  logic                   in_valid;
  logic [PIN_W-1:0]       in_data;
  logic                   in_ready;
  logic [7:0]             word_count;
  logic                   loaded;
  logic                   frame_done;
  logic                   overflow;
  logic [PIN_W-1:0]       checksum;
  logic [0:PIN_W*WORDS-1] mem;

  int n_cmp = 0;
  int n_bad = 0;

  logic [PIN_W-1:0] exp_mem [WORDS];
  int               exp_cnt;

  image_loader #(.PIN_W(PIN_W), .WORDS(WORDS)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .clear      (clear),
    .hold       (hold),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .word_count (word_count),
    .loaded     (loaded),
    .frame_done (frame_done),
    .overflow   (overflow),
    .checksum   (checksum),
    .mem        (mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [PIN_W-1:0] word_of(input int mode, input int k);
    case (mode)
      0:       return PIN_W'(k);
      1:       return 12'hA5A;
      default: return PIN_W'(k + 1);
    endcase
  endfunction

  task automatic check_mem(input string tag);
    for (int i = 0; i < WORDS; i++) check_eq(tag, 32'(mem[i*PIN_W +: PIN_W]), 32'(exp_mem[i]));
  endtask

  task automatic zero_model();
    for (int i = 0; i < WORDS; i++) exp_mem[i] = '0;
    exp_cnt = 0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    #1;
    check_eq("clear_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    clear = 1'b0;
    exp_cnt = 0;
    check_eq("clear_overflow", 32'(overflow), 32'd0);
    check_eq("clear_loaded", 32'(loaded), 32'd0);
    check_eq("clear_count", 32'(word_count), 32'd0);
    check_eq("clear_checksum", 32'(checksum), 32'd0);
  endtask

  // Streams n words with in_valid high; optional 10-cycle hold window and clear on the last word.
  task automatic send_words(input int mode, input int n, input int hold_start, input bit clr_last);
    int  k;
    int  cyc;
    bit  acc;
    bit  pulse;
    k   = 0;
    cyc = 0;
    while (k < n && cyc < n + 40) begin
      hold     = (hold_start >= 0) && (cyc >= hold_start) && (cyc < hold_start + 10);
      in_valid = 1'b1;
      in_data  = word_of(mode, k);
      clear    = clr_last && (k == n - 1);
      #1;
      if (hold) begin
        check_eq("hold_ready", 32'(in_ready), 32'd0);
        check_eq("hold_count", 32'(word_count), 32'(hold_start));
      end
      @(posedge clk);
      acc   = !hold && !clear && (exp_cnt < WORDS);
      pulse = 1'b0;
      if (clear) begin
        exp_cnt = 0;
        k = n;
      end else if (acc) begin
        exp_mem[exp_cnt] = in_data;
        exp_cnt++;
        pulse = (exp_cnt == WORDS);
        k++;
      end
      cyc++;
      @(negedge clk);
      in_valid = 1'b0;
      clear    = 1'b0;
      hold     = 1'b0;
      check_eq("frame_done", 32'(frame_done), 32'(pulse));
      check_eq("word_count", 32'(word_count), 32'(exp_cnt));
    end
    check_eq("send_budget", 32'(k), 32'(n));
  endtask

  initial begin
    rst_b    = 1'b0;
    clear    = 1'b0;
    hold     = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    zero_model();

    // reset state and combinational in_ready
    repeat (2) @(negedge clk);
    check_eq("rst_count", 32'(word_count), 32'd0);
    check_eq("rst_loaded", 32'(loaded), 32'd0);
    check_eq("rst_done", 32'(frame_done), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_checksum", 32'(checksum), 32'd0);
    check_eq("rst_mem", 32'(|mem), 32'd0);
    check_eq("rst_ready", 32'(in_ready), 32'd1);
    hold = 1'b1; #1;
    check_eq("rst_ready_hold", 32'(in_ready), 32'd0);
    hold = 1'b0; clear = 1'b1; #1;
    check_eq("rst_ready_clear", 32'(in_ready), 32'd0);
    clear = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);

    // frame 1: words 0..199, hold during cycles 50..59
    send_words(0, WORDS, 50, 1'b0);
    check_eq("f1_loaded", 32'(loaded), 32'd1);
    check_eq("f1_count", 32'(word_count), 32'd200);
    check_eq("f1_overflow", 32'(overflow), 32'd0);
    check_eq("f1_checksum", 32'(checksum), 32'd0);
    check_mem("f1_mem");

    // overflow in FULL
    in_valid = 1'b1;
    in_data  = 12'hFFF;
    #1;
    check_eq("full_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("ovf_set", 32'(overflow), 32'd1);
    check_eq("ovf_done", 32'(frame_done), 32'd0);
    check_eq("ovf_count", 32'(word_count), 32'd200);
    check_mem("ovf_mem");
    @(negedge clk);
    check_eq("ovf_sticky", 32'(overflow), 32'd1);

    // clear in FULL, then a frame of A5A
    do_clear();
    check_mem("clear_mem_kept");
    send_words(1, WORDS, -1, 1'b0);
    check_eq("f2_loaded", 32'(loaded), 32'd1);
    check_mem("f2_mem");

    // clear coincident with the last-word accept
    do_clear();
    send_words(0, WORDS, -1, 1'b1);
    check_eq("clrlast_loaded", 32'(loaded), 32'd0);
    check_eq("clrlast_count", 32'(word_count), 32'd0);
    check_mem("clrlast_mem");

    // asynchronous reset mid-frame at word 120
    send_words(2, 120, -1, 1'b0);
    check_eq("mid_count", 32'(word_count), 32'd120);
    rst_b = 1'b0;
    #1;
    zero_model();
    check_eq("arst_mem", 32'(|mem), 32'd0);
    check_eq("arst_count", 32'(word_count), 32'd0);
    check_eq("arst_loaded", 32'(loaded), 32'd0);
    check_eq("arst_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    check_eq("arst_done_after", 32'(frame_done), 32'd0);

    // words 1..200: checksum 12'h0C8 when enabled, otherwise tied to 0
    send_words(2, WORDS, -1, 1'b0);
    check_eq("f3_loaded", 32'(loaded), 32'd1);
`ifdef LOADER_CHECKSUM_EN
    check_eq("f3_checksum", 32'(checksum), 32'h0C8);
`else
    check_eq("f3_checksum", 32'(checksum), 32'h000);
`endif
    check_mem("f3_mem");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
